// File: rtl/symbol_draw_ctrl.sv
// symbol_draw_ctrl
//
// Purpose: sequences an animated 16x16 symbol on a 160x120 VGA frame.
// Each animation step goes through these phases:
//   1. Erase the box at the current origin (256-cycle sweep, colour 000).
//   2. Enable the external draw engine until it reports completion.
//   3. Hold for DELAY_CYCLES.
//   4. Move the origin by STEP pixels in the direction given by dir.
// The block returns to idle at the end of a hold when run has dropped.
//
// Parameters:
//   DELAY_CYCLES  hold time between steps in clk cycles (>= 1)
//   STEP          pixels moved per step (1..15)
//
// Configuration macro:
//   SYMBOL_CTRL_WRAP_EN  when defined, moves wrap around the legal origin
//                        range instead of clamping at its edges.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   run        level request: 1 animate, 0 stop at the end of the hold
//   x_init     origin x loaded when leaving idle
//   y_init     origin y loaded when leaving idle
//   dir        move direction: 00 +x, 01 -x, 10 +y, 11 -y
//   draw_go    draw engine enable (engine clears its counter while low)
//   draw_next  engine completion pulse
//   base_x     current origin x
//   base_y     current origin y
//   plot       VGA write enable, one cycle behind the phase that produces it
//   erase_x    erase sweep pixel x
//   erase_y    erase sweep pixel y
//   erase_sel  pixel mux select: 1 erase pixel (colour 000), 0 engine pixel
//   busy       high whenever the controller is not idle
module symbol_draw_ctrl #(
  parameter int DELAY_CYCLES = 833333,
  parameter int STEP         = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic [7:0] x_init,
  input  logic [6:0] y_init,
  input  logic [1:0] dir,
  output logic       draw_go,
  input  logic       draw_next,
  output logic [7:0] base_x,
  output logic [6:0] base_y,
  output logic       plot,
  output logic [7:0] erase_x,
  output logic [6:0] erase_y,
  output logic       erase_sel,
  output logic       busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ERASE = 3'd1;
  localparam logic [2:0] DRAW  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] MOVE  = 3'd4;

  localparam int              DW         = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [DW-1:0]   DELAY_LAST = DW'(DELAY_CYCLES - 1);
  localparam logic signed [9:0] STEP_S   = 10'(STEP);
  localparam logic signed [9:0] X_MAX    = 10'sd144;
  localparam logic signed [9:0] Y_MAX    = 10'sd104;

  logic [2:0]    state_q, state_d;
  logic [7:0]    sweep_q, sweep_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [7:0]    base_x_q, base_x_d;
  logic [6:0]    base_y_q, base_y_d;
  logic          plot_q;
  logic          erase_sel_q;
  logic [7:0]    erase_x_q;
  logic [6:0]    erase_y_q;

  // Origins widened to signed 10 bits so a step below zero stays visible
  // as a negative value instead of wrapping modulo 256/128.
  logic signed [9:0] xWide;
  logic signed [9:0] yWide;

  assign xWide = {2'b00, base_x_q};
  assign yWide = {3'b000, base_y_q};

  // Brings a stepped coordinate back into [0, maxV], either by clamping at
  // the edges or by wrapping across the range when wrap mode is built in.
  function automatic logic [7:0] fitCoord(input logic signed [9:0] v,
                                          input logic signed [9:0] maxV);
    logic signed [9:0] r;
    r = v;
`ifdef SYMBOL_CTRL_WRAP_EN
    if (v > maxV)
      r = v - maxV - 10'sd1;
    else if (v < 10'sd0)
      r = v + maxV + 10'sd1;
`else
    if (v > maxV)
      r = maxV;
    else if (v < 10'sd0)
      r = 10'sd0;
`endif
    return 8'(r);
  endfunction

  // Next-state logic for the animation sequence. The sweep counter wraps
  // back to zero by itself after the 256th erase cycle. The delay counter
  // is cleared as WAIT exits, so every hold starts from zero. run is
  // sampled only in IDLE and at the end of WAIT, so dropping it mid-step
  // never cuts an erase or a draw short.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    delay_d  = delay_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          base_x_d = x_init;
          base_y_d = y_init;
          state_d  = ERASE;
        end
      end
      ERASE: begin
        sweep_d = sweep_q + 8'd1;
        if (sweep_q == 8'hFF)
          state_d = DRAW;
      end
      DRAW: begin
        if (draw_next)
          state_d = WAIT;
      end
      WAIT: begin
        if (delay_q == DELAY_LAST) begin
          delay_d = '0;
          state_d = run ? MOVE : IDLE;
        end else begin
          delay_d = delay_q + DW'(1);
        end
      end
      MOVE: begin
        case (dir)
          2'b00: base_x_d = fitCoord(xWide + STEP_S, X_MAX);
          2'b01: base_x_d = fitCoord(xWide - STEP_S, X_MAX);
          2'b10: base_y_d = 7'(fitCoord(yWide + STEP_S, Y_MAX));
          2'b11: base_y_d = 7'(fitCoord(yWide - STEP_S, Y_MAX));
        endcase
        state_d = ERASE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers and the pixel-side pipeline stage. plot, erase_sel and
  // the erase coordinates are all registered together. This keeps the erase
  // pixel, the mux select and the write enable in step with the draw
  // engine's own one-cycle output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sweep_q     <= 8'd0;
      delay_q     <= '0;
      base_x_q    <= 8'd0;
      base_y_q    <= 7'd0;
      plot_q      <= 1'b0;
      erase_sel_q <= 1'b0;
      erase_x_q   <= 8'd0;
      erase_y_q   <= 7'd0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      delay_q     <= delay_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      plot_q      <= (state_q == ERASE) || (state_q == DRAW);
      erase_sel_q <= (state_q == ERASE);
      erase_x_q   <= base_x_q + {4'b0000, sweep_q[3:0]};
      erase_y_q   <= base_y_q + {3'b000, sweep_q[7:4]};
    end
  end

  // draw_go is decoded straight from the state register, so an asynchronous
  // reset drops it, and with it the engine counter, immediately.
  assign draw_go   = (state_q == DRAW);
  assign busy      = (state_q != IDLE);
  assign base_x    = base_x_q;
  assign base_y    = base_y_q;
  assign plot      = plot_q;
  assign erase_sel = erase_sel_q;
  assign erase_x   = erase_x_q;
  assign erase_y   = erase_y_q;

endmodule

// File: doc/symbol_draw_ctrl.md
SYMBOL_DRAW_CTRL -- requirements
Module: symbol_draw_ctrl

Interface
REQ-001 Parameter DELAY_CYCLES, default 833333, sets the hold time between animation steps in clk cycles, with a minimum of 1.
REQ-002 Parameter STEP, default 1, sets the pixels moved per animation step, range 1..15.
REQ-003 Port clk, input, 1, is the system clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, is the asynchronous, active-low reset.
REQ-005 Port run, input, 1, is a level: 1 requests animation, 0 requests a stop.
REQ-006 Port x_init, input, 8, is the symbol origin x, loaded when leaving IDLE.
REQ-007 Port y_init, input, 7, is the symbol origin y, loaded when leaving IDLE.
REQ-008 Port dir, input, 2, is the move direction: 00 right (+x), 01 left (-x), 10 down (+y), 11 up (-y).
REQ-009 Port draw_go, output, 1, is the enable to the symbol draw engine; the engine counts while it is high and clears while it is low.
REQ-010 Port draw_next, input, 1, is the engine done pulse, high when the engine's 6-bit count equals 36.
REQ-011 Port base_x, output, 8, and base_y, output, 7, are the current symbol origin driven to the engine.
REQ-012 Port plot, output, 1, is the VGA write enable.
REQ-013 Ports erase_x, output, 8, and erase_y, output, 7, are the erase-sweep pixel coordinates.
REQ-014 Port erase_sel, output, 1: 1 selects the erase coordinates with colour 000 on the pixel mux, 0 selects the engine pixel.
REQ-015 Port busy, output, 1, is high in every state except IDLE.

Function
REQ-016 The FSM shall have states IDLE, ERASE, DRAW, WAIT and MOVE.
REQ-017 IDLE with run=1 shall load base_x=x_init and base_y=y_init and go to ERASE; IDLE with run=0 shall stay in IDLE.
REQ-018 ERASE shall sweep a 16x16 box at the base over 256 cycles (x offset fastest, 0..15, then y offset); erase_x=base_x+xo and erase_y=base_y+yo with 8-bit/7-bit truncation; it then goes to DRAW.
REQ-019 DRAW shall hold draw_go=1 from its first cycle until the cycle draw_next is sampled 1, then drop draw_go and go to WAIT.
REQ-020 A draw_next seen outside DRAW shall be ignored.
REQ-021 plot shall be a 1-cycle-registered copy of "state is ERASE or DRAW", matching the engine's 1-cycle output register.
REQ-022 erase_sel shall be registered alongside plot so the mux select and plot stay aligned.
REQ-023 WAIT shall count DELAY_CYCLES cycles and then go to MOVE if run=1, or to IDLE if run=0; the base is not changed on the path to IDLE.
REQ-024 MOVE shall last 1 cycle, apply STEP in the direction given by dir sampled in that cycle, then go to ERASE.
REQ-025 Boundary limits: x is clamped to [0,144] and y to [0,104], with 160x120 screen and 16x16 box, unless REQ-031 applies.
REQ-026 A step that would underflow below 0 shall give 0, never a modular wrap.
REQ-027 run dropping during ERASE or DRAW shall not abort the state; the block stops only at the end of WAIT.
REQ-028 dir changes outside MOVE shall have no effect.

Reset
REQ-029 When reset_n=0, regardless of clk: state=IDLE, draw_go=0, plot=0, erase_sel=0, busy=0, base_x=0, base_y=0, erase_x=0, erase_y=0, and the sweep and delay counters are 0.
REQ-030 Reset asserted mid-DRAW shall drop draw_go at once, which also clears the engine counter; after release the FSM waits in IDLE for run.

Configuration
REQ-031 With macro SYMBOL_CTRL_WRAP_EN defined, MOVE shall wrap instead of clamp: x past 144 becomes (x-145) and x below 0 becomes (145+x); y is handled the same way with 104/105. Without the macro, REQ-025 and REQ-026 clamping applies.

Verification (DELAY_CYCLES=4, STEP=1, engine model pulses draw_next on the 36th go-high cycle)
REQ-032 Reset, then run=1, x_init=10, y_init=20 -> base 10,20; 256 plot cycles with erase_sel=1; first erase pixel (10,20), last (25,35).
REQ-033 DRAW -> draw_go high for exactly 36 cycles, draw_next seen once, plot high 1 cycle later than draw_go and for 36 cycles.
REQ-034 dir=00 for 3 steps from x=142 -> base_x sequence 143, 144, 144 without macro; 143, 144, 0 with SYMBOL_CTRL_WRAP_EN.
REQ-035 dir=01 from x=0 -> base_x stays 0 (clamp), or becomes 144 with macro.
REQ-036 run=0 during DRAW -> DRAW completes, WAIT runs 4 cycles, then IDLE with busy=0 and base unchanged.
REQ-037 reset_n pulsed low mid-DRAW -> draw_go, plot and busy are 0 in the same cycle, base is 0, and the FSM sits in IDLE until run=1.
